// File: rtl/hbuf_pg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hbuf_pg_reader
//  Purpose  : Requests one hit-buffer page from DDR3 via a four-phase
//             req/ack handshake, then walks the page DPRAM entry by entry and
//             streams each 128-bit entry out as four 32-bit words, LSB first.
//  Revision : 1.0  initial release
// ============================================================================
module hbuf_pg_reader #(
  parameter int P_PG_ENTRIES      = 256,
  parameter int P_DPRAM_ADR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         hbuf_empty,
  input  logic [15:0]                  hbuf_rd_pg_num,
  output logic                         hbuf_pg_done,
  output logic                         pg_req,
  output logic                         pg_optype,
  output logic [27:0]                  pg_addr,
  input  logic                         pg_ack,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
  input  logic [127:0]                 dpram_dout,
  output logic [31:0]                  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic [15:0]                  pages_read
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DROP  = 3'd2,
    S_FETCH = 3'd3,
    S_LOAD  = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [P_DPRAM_ADR_WIDTH-1:0] C_LAST_ENTRY = P_DPRAM_ADR_WIDTH'(P_PG_ENTRIES - 1);
  localparam logic [1:0]                   C_LAST_LANE  = 2'd3;

  state_t                         state_q, state_d;
  logic [27:0]                    pg_addr_q, pg_addr_d;
  logic [P_DPRAM_ADR_WIDTH-1:0]   entry_q, entry_d;
  logic [1:0]                     lane_q, lane_d;
  logic [127:0]                   holding_q, holding_d;
  logic [15:0]                    pages_read_q, pages_read_d;

  logic w_in_shift;
  logic w_xfer;
  logic w_last_entry;

  assign w_in_shift   = (state_q == S_SHIFT);
  assign w_xfer       = w_in_shift && out_ready;
  assign w_last_entry = (entry_q == C_LAST_ENTRY);

  // State and datapath registers; reset returns everything to an idle, zeroed block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pg_addr_q    <= 28'd0;
      entry_q      <= '0;
      lane_q       <= 2'd0;
      holding_q    <= 128'd0;
      pages_read_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      pg_addr_q    <= pg_addr_d;
      entry_q      <= entry_d;
      lane_q       <= lane_d;
      holding_q    <= holding_d;
      pages_read_q <= pages_read_d;
    end
  end

  // Next-state and datapath update: request page, wait for ack to drop, then fetch/load/shift each entry.
  always_comb begin
    state_d      = state_q;
    pg_addr_d    = pg_addr_q;
    entry_d      = entry_q;
    lane_d       = lane_q;
    holding_d    = holding_q;
    pages_read_d = pages_read_q;

    case (state_q)
      S_IDLE: begin
        // Page number and address are captured only here so later changes on the
        // hit-buffer side cannot disturb a page in flight.
        if (en && !hbuf_empty) begin
          pg_addr_d = {1'b0, hbuf_rd_pg_num, 11'b0};
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (pg_ack) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (!pg_ack) begin
          entry_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Read address is presented this cycle; DPRAM data arrives in LOAD.
        state_d = S_LOAD;
      end
      S_LOAD: begin
        holding_d = dpram_dout;
        lane_d    = 2'd0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_xfer) begin
          if (lane_q == C_LAST_LANE) begin
            if (w_last_entry) begin
              state_d = S_DONE;
            end else begin
              entry_d = entry_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        pages_read_d = pages_read_q + 16'd1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pg_req        = (state_q == S_REQ);
  assign pg_optype     = 1'b0;
  assign pg_addr       = pg_addr_q;
  assign dpram_rd_addr = entry_q;
  assign out_valid     = w_in_shift;
  assign out_data      = holding_q[{lane_q, 5'd0} +: 32];
  assign out_last      = w_in_shift && (lane_q == C_LAST_LANE) && w_last_entry;
  assign hbuf_pg_done  = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign pages_read    = pages_read_q;

endmodule
`default_nettype wire

// File: tb/tb_hbuf_pg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hbuf_pg_reader
//  Purpose  : Directed self-checking bench for hbuf_pg_reader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hbuf_pg_reader;

  localparam int NWORDS = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         hbuf_empty;
  logic [15:0]  hbuf_rd_pg_num;
  logic         hbuf_pg_done;
  logic         pg_req;
  logic         pg_optype;
  logic [27:0]  pg_addr;
  logic         pg_ack;
  logic [7:0]   dpram_rd_addr;
  logic [127:0] dpram_dout = 128'd0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [15:0]  pages_read;

  logic [127:0] mem [0:255];

  int vectors = 0;
  int fails   = 0;

  int   ack_delay   = 3;
  int   req_cnt     = 0;
  bit   ack_manual  = 1'b0;
  logic pg_ack_auto = 1'b0;
  logic pg_ack_man  = 1'b0;

  assign pg_ack = ack_manual ? pg_ack_man : pg_ack_auto;

  hbuf_pg_reader #(
    .P_PG_ENTRIES      (256),
    .P_DPRAM_ADR_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .hbuf_empty     (hbuf_empty),
    .hbuf_rd_pg_num (hbuf_rd_pg_num),
    .hbuf_pg_done   (hbuf_pg_done),
    .pg_req         (pg_req),
    .pg_optype      (pg_optype),
    .pg_addr        (pg_addr),
    .pg_ack         (pg_ack),
    .dpram_rd_addr  (dpram_rd_addr),
    .dpram_dout     (dpram_dout),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .pages_read     (pages_read)
  );

  always #5 clk = ~clk;

  // Expected stream word for linear word index w (entry = w/4, lane = w%4).
  function automatic logic [31:0] word_of(input int w);
    return 32'h5A00_0000 ^ (32'(w) * 32'h0001_0003);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) begin
        mem[i][32*k +: 32] = word_of(i*4 + k);
      end
    end
  end

  // Page DPRAM model: registered read, one cycle latency.
  always @(posedge clk) dpram_dout <= mem[dpram_rd_addr];

  // Four-phase DDR3 responder: raise ack a few cycles into the request, drop it once req drops.
  always @(negedge clk) begin
    if (pg_req) begin
      if (req_cnt >= ack_delay) pg_ack_auto = 1'b1;
      req_cnt = req_cnt + 1;
    end else begin
      req_cnt     = 0;
      pg_ack_auto = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic start_page(input logic [15:0] pg, input logic [27:0] exp_addr, input bit keep_pending);
    @(negedge clk);
    hbuf_rd_pg_num = pg;
    hbuf_empty     = 1'b0;
    en             = 1'b1;
    @(negedge clk);
    vectors++;
    if (pg_req !== 1'b1) begin
      fails++; $display("FAIL start_req: pg_req got %b want 1", pg_req);
    end
    vectors++;
    if (pg_addr !== exp_addr) begin
      fails++; $display("FAIL start_addr: pg_addr got %h want %h", pg_addr, exp_addr);
    end
    if (!keep_pending) hbuf_empty = 1'b1;
    hbuf_rd_pg_num = ~pg;
  endtask

  task automatic drain_page(input bit rnd_ready, input int en_off_word,
                            output int nwords, output int ndone, output int span);
    int  widx = 0;
    int  t0   = -1;
    int  cyc  = 0;
    bit  seen = 1'b0;
    nwords = 0; ndone = 0; span = 0;
    out_ready = 1'b1;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (hbuf_pg_done) begin
        ndone++; seen = 1'b1; span = cyc - t0;
      end
      vectors++;
      if (!out_valid && out_last !== 1'b0) begin
        fails++; $display("FAIL last_idle: out_last got %b want 0 (w=%0d)", out_last, widx);
      end
      if (out_valid) begin
        if (t0 < 0) t0 = cyc;
        vectors++;
        if (out_data !== word_of(widx)) begin
          fails++; $display("FAIL data: word %0d got %h want %h", widx, out_data, word_of(widx));
        end
        vectors++;
        if (out_last !== 1'(widx == NWORDS-1)) begin
          fails++; $display("FAIL last: word %0d got %b want %b", widx, out_last, (widx == NWORDS-1));
        end
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) widx++;
        if (en_off_word >= 0 && widx == en_off_word) en = 1'b0;
      end
    end
    nwords = widx;
    out_ready = 1'b1;
    vectors++;
    if (!seen) begin
      fails++; $display("FAIL drain_timeout: got no hbuf_pg_done within %0d cycles, want one", cyc);
    end
    @(negedge clk);
    vectors++;
    if (hbuf_pg_done !== 1'b0) begin
      fails++; $display("FAIL done_width: hbuf_pg_done got %b want 0 one cycle after pulse", hbuf_pg_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; hbuf_empty = 1'b1; hbuf_rd_pg_num = 16'h0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({pg_req, out_valid, out_last, hbuf_pg_done, busy, pg_optype} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: {req,valid,last,done,busy,optype} got %b want 000000",
                        {pg_req, out_valid, out_last, hbuf_pg_done, busy, pg_optype});
    end
    vectors++;
    if ({pages_read, pg_addr, dpram_rd_addr, out_data} !== 84'd0) begin
      fails++; $display("FAIL reset_data: pr=%h addr=%h rda=%h data=%h want all 0",
                        pages_read, pg_addr, dpram_rd_addr, out_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic_page;
    int nw, nd, sp;
    start_page(16'h0003, 28'h0001800, 1'b0);
    drain_page(1'b0, -1, nw, nd, sp);
    vectors++;
    if (nw !== NWORDS) begin fails++; $display("FAIL basic_words: got %0d want %0d", nw, NWORDS); end
    vectors++;
    if (nd !== 1) begin fails++; $display("FAIL basic_done: got %0d pulses want 1", nd); end
    vectors++;
    if (sp !== 1534) begin fails++; $display("FAIL basic_rate: first word to done got %0d cycles want 1534", sp); end
    vectors++;
    if (pages_read !== 16'd1) begin fails++; $display("FAIL basic_pages: got %0d want 1", pages_read); end
    vectors++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle: busy got %b want 0", busy); end
    vectors++;
    if (pg_addr !== 28'h0001800) begin fails++; $display("FAIL basic_addr_hold: got %h want 0001800", pg_addr); end
  endtask

  task automatic test_backpressure;
    int nw, nd, sp;
    start_page(16'h00A5, 28'h0052800, 1'b0);
    drain_page(1'b1, -1, nw, nd, sp);
    vectors++;
    if (nw !== NWORDS) begin fails++; $display("FAIL bp_words: got %0d want %0d", nw, NWORDS); end
    vectors++;
    if (nd !== 1) begin fails++; $display("FAIL bp_done: got %0d pulses want 1", nd); end
    vectors++;
    if (pages_read !== 16'd2) begin fails++; $display("FAIL bp_pages: got %0d want 2", pages_read); end
  endtask

  task automatic test_en_drop;
    int nw, nd, sp;
    start_page(16'h7FFF, 28'h3FFF800, 1'b1);
    drain_page(1'b0, 400, nw, nd, sp);
    vectors++;
    if (nw !== NWORDS) begin fails++; $display("FAIL endrop_words: got %0d want %0d", nw, NWORDS); end
    vectors++;
    if (nd !== 1) begin fails++; $display("FAIL endrop_done: got %0d pulses want 1", nd); end
    vectors++;
    if (pages_read !== 16'd3) begin fails++; $display("FAIL endrop_pages: got %0d want 3", pages_read); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, pg_req} !== 2'b00) begin
        fails++; $display("FAIL endrop_idle: cycle %0d {busy,req} got %b want 00", i, {busy, pg_req});
      end
    end
  endtask

  task automatic test_ack_early;
    int nw, nd, sp;
    ack_manual = 1'b1;
    pg_ack_man = 1'b1;
    start_page(16'h0001, 28'h0000800, 1'b0);
    @(negedge clk);
    vectors++;
    if ({pg_req, busy} !== 2'b01) begin
      fails++; $display("FAIL ack_req_len: {req,busy} got %b want 01", {pg_req, busy});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({pg_req, out_valid, busy} !== 3'b001) begin
        fails++; $display("FAIL ack_drop_wait: cycle %0d {req,valid,busy} got %b want 001", i, {pg_req, out_valid, busy});
      end
    end
    pg_ack_man = 1'b0;
    drain_page(1'b0, -1, nw, nd, sp);
    ack_manual = 1'b0;
    vectors++;
    if (nw !== NWORDS) begin fails++; $display("FAIL ack_words: got %0d want %0d", nw, NWORDS); end
    vectors++;
    if (pages_read !== 16'd4) begin fails++; $display("FAIL ack_pages: got %0d want 4", pages_read); end
  endtask

  task automatic test_reset_mid;
    int widx = 0;
    int cyc  = 0;
    bit hit  = 1'b0;
    start_page(16'h0002, 28'h0001000, 1'b1);
    out_ready = 1'b1;
    while (!hit && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (widx == 200) begin
          rst = 1'b1; en = 1'b0; hit = 1'b1;
        end else begin
          widx++;
        end
      end
    end
    vectors++;
    if (!hit) begin fails++; $display("FAIL rstmid_reach: got word %0d want 200", widx); end
    @(negedge clk);
    vectors++;
    if ({pg_req, out_valid, out_last, hbuf_pg_done, busy} !== 5'b0) begin
      fails++; $display("FAIL rstmid_ctrl: {req,valid,last,done,busy} got %b want 00000",
                        {pg_req, out_valid, out_last, hbuf_pg_done, busy});
    end
    vectors++;
    if ({pages_read, pg_addr, dpram_rd_addr, out_data} !== 84'd0) begin
      fails++; $display("FAIL rstmid_data: pr=%h addr=%h rda=%h data=%h want all 0",
                        pages_read, pg_addr, dpram_rd_addr, out_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({hbuf_pg_done, busy} !== 2'b00) begin
        fails++; $display("FAIL rstmid_after: cycle %0d {done,busy} got %b want 00", i, {hbuf_pg_done, busy});
      end
    end
  endtask

  task automatic test_wrap;
    int nw, nd, sp;
    @(negedge clk);
    force dut.pages_read_q = 16'hFFFF;
    @(negedge clk);
    release dut.pages_read_q;
    start_page(16'hFFFF, 28'h7FFF800, 1'b0);
    drain_page(1'b0, -1, nw, nd, sp);
    vectors++;
    if (nd !== 1) begin fails++; $display("FAIL wrap_done: got %0d pulses want 1", nd); end
    vectors++;
    if (pages_read !== 16'd0) begin fails++; $display("FAIL wrap_pages: got %h want 0000", pages_read); end
  endtask

  initial begin
    test_reset();
    test_basic_page();
    test_backpressure();
    test_en_drop();
    test_ack_early();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hbuf_pg_reader.md
HBUF_PG_READER -- requirements
Module: hbuf_pg_reader

Interface
REQ-001 Parameter P_PG_ENTRIES, default 256, SHALL set the number of 128-bit DPRAM entries per hit-buffer page.
REQ-002 Parameter P_DPRAM_ADR_WIDTH, default 8, SHALL set the DPRAM read-address width; P_PG_ENTRIES = 2**P_DPRAM_ADR_WIDTH.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high. Ports are listed below as name, direction, width, meaning.
REQ-004 clk  in  1  logic clock (lclk); all logic on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 en  in  1  enables starting new page reads.
REQ-007 hbuf_empty  in  1  hit buffer holds no unread pages.
REQ-008 hbuf_rd_pg_num  in  16  next page to read.
REQ-009 hbuf_pg_done  out  1  one-cycle pulse: current page fully consumed.
REQ-010 pg_req  out  1  DDR3 page-transfer request (four-phase).
REQ-011 pg_optype  out  1  transfer type, tied 0 (read).
REQ-012 pg_addr  out  28  DDR3 page address.
REQ-013 pg_ack  in  1  DDR3 page-transfer acknowledge.
REQ-014 dpram_rd_addr  out  P_DPRAM_ADR_WIDTH  page DPRAM read address.
REQ-015 dpram_dout  in  128  page DPRAM read data, valid 1 cycle after address.
REQ-016 out_data  out  32  output stream word.
REQ-017 out_valid / out_ready  out / in  1 / 1  stream handshake; a transfer occurs when both are high on a clock edge.
REQ-018 out_last  out  1  marks the final 32-bit word of a page.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 pages_read  out  16  count of completed pages; wraps at 16'hffff -> 0.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, DROP, FETCH, LOAD, SHIFT and DONE.
REQ-022 IDLE: when en=1 and hbuf_empty=0, the block SHALL latch hbuf_rd_pg_num, set pg_addr = {1'b0, pg_num, 11'b0}, and go to REQ.
REQ-023 REQ: pg_req SHALL be 1; when pg_ack=1 the FSM SHALL go to DROP.
REQ-024 DROP: pg_req SHALL be 0; when pg_ack=0 the FSM SHALL clear the entry counter and go to FETCH.
REQ-025 FETCH: dpram_rd_addr SHALL equal the entry counter; the FSM SHALL go to LOAD on the next cycle.
REQ-026 LOAD: the block SHALL capture dpram_dout into a 128-bit holding register, clear the lane counter, and go to SHIFT.
REQ-027 SHIFT: out_valid SHALL be 1 and out_data SHALL be holding[32*lane+31 : 32*lane], lane 0 (LSBs) first; the lane SHALL advance only on a transfer.
REQ-028 When the transfer of lane 3 occurs in SHIFT: if entry = P_PG_ENTRIES-1 the FSM SHALL go to DONE; otherwise it SHALL increment entry and go to FETCH.
REQ-029 out_last SHALL be 1 only while in SHIFT with lane=3 and entry=P_PG_ENTRIES-1.
REQ-030 DONE: hbuf_pg_done SHALL be 1 for exactly one cycle, pages_read SHALL increment, and the FSM SHALL go to IDLE.
REQ-031 With out_ready held high, throughput SHALL be 4 words per 6 cycles.
REQ-032 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-033 en SHALL be sampled only in IDLE; deasserting en mid-page SHALL let the page complete.
REQ-034 hbuf_empty and hbuf_rd_pg_num changes outside IDLE SHALL be ignored.
REQ-035 A pg_ack already high on entry to REQ SHALL be honoured on that cycle (REQ lasts 1 cycle).
REQ-036 out_valid SHALL be 0 in every state except SHIFT.
REQ-037 pg_optype SHALL be 0 always.

Reset
REQ-038 On rst=1 the block SHALL enter IDLE with pg_req=0, out_valid=0, out_last=0, hbuf_pg_done=0, busy=0, pages_read=0, pg_addr=0, dpram_rd_addr=0, and out_data=0.
REQ-039 Reset mid-page SHALL abort without an hbuf_pg_done pulse and drop pg_req on the next edge.

Verification
REQ-040 Bench: hbuf_rd_pg_num=16'h0003, en=1, empty=0, pg_ack 3 cycles after pg_req -> pg_addr=28'h0001800; 1024 words, lane order LSB-first; out_last only on word 1023; one hbuf_pg_done pulse; pages_read=1.
REQ-041 Bench: random out_ready backpressure (50%) -> output equals the DPRAM contents in order, with no drop or duplicate, and data stable while stalled.
REQ-042 Bench: en deasserted at entry 100 -> page completes, then the FSM stays in IDLE with busy=0.
REQ-043 Bench: rst pulsed during SHIFT at entry 50 -> all outputs at reset values next cycle, with no hbuf_pg_done pulse.
REQ-044 Bench: pages_read preset by 65535 completions plus one more -> pages_read=0.
REQ-045 Bench: pg_ack held high before the request -> REQ lasts 1 cycle, and DROP waits until pg_ack falls.
